// File: rtl/neander_pkg.sv
// Shared constants for the Neander control unit, datapath and ALU:
// opcodes, FSM state encoding, ALU select codes and the decoded instruction class.
package neander_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] S_T0   = 4'd0;
  localparam logic [3:0] S_T1   = 4'd1;
  localparam logic [3:0] S_T2   = 4'd2;
  localparam logic [3:0] S_T3   = 4'd3;
  localparam logic [3:0] S_T4   = 4'd4;
  localparam logic [3:0] S_T5   = 4'd5;
  localparam logic [3:0] S_T6   = 4'd6;
  localparam logic [3:0] S_T7   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_AND    = 3'd1;
  localparam logic [2:0] ALU_OR     = 3'd2;
  localparam logic [2:0] ALU_NOT    = 3'd3;
  localparam logic [2:0] ALU_PASS_Y = 3'd4;

  typedef struct packed {
    logic nop;
    logic sta;
    logic lda;
    logic add;
    logic lor;
    logic land;
    logic lnot;
    logic jmp;
    logic jn;
    logic jz;
    logic hlt;
  } instr_class_t;

  // Instructions that fetch an operand address and touch memory in T5..T7.
  function automatic logic is_mem_ref(input instr_class_t c);
    return c.sta | c.lda | c.add | c.lor | c.land;
  endfunction

endpackage

// File: rtl/neander_control_unit_if.sv
// Control-unit <-> datapath bundle: opcode/flags into the controller,
// register strobes, mux selects and ALU select out of it.
interface neander_control_unit_if #(
  parameter int OPCODE_WIDTH  = 4,
  parameter int ALU_SEL_WIDTH = 3
);
  logic [OPCODE_WIDTH-1:0]  opcode;
  logic                     flag_n;
  logic                     flag_z;
  logic                     load_rem;
  logic                     load_rdm;
  logic                     load_ri;
  logic                     load_ac;
  logic                     load_nz;
  logic                     load_pc;
  logic                     inc_pc;
  logic                     sel_addr;
  logic                     sel_rdm;
  logic                     mem_write;
  logic [ALU_SEL_WIDTH-1:0] alu_sel;
  logic                     halted;

  modport master (
    input  opcode, flag_n, flag_z,
    output load_rem, load_rdm, load_ri, load_ac, load_nz, load_pc,
           inc_pc, sel_addr, sel_rdm, mem_write, alu_sel, halted
  );

  modport slave (
    output opcode, flag_n, flag_z,
    input  load_rem, load_rdm, load_ri, load_ac, load_nz, load_pc,
           inc_pc, sel_addr, sel_rdm, mem_write, alu_sel, halted
  );
endinterface

// File: rtl/neander_decoder.sv
// Opcode to one-hot instruction class; unassigned opcodes decode as NOP.
module neander_decoder
  import neander_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4
) (
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  output instr_class_t            cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OPCODE_WIDTH'(OP_STA): cls_o.sta  = 1'b1;
      OPCODE_WIDTH'(OP_LDA): cls_o.lda  = 1'b1;
      OPCODE_WIDTH'(OP_ADD): cls_o.add  = 1'b1;
      OPCODE_WIDTH'(OP_OR):  cls_o.lor  = 1'b1;
      OPCODE_WIDTH'(OP_AND): cls_o.land = 1'b1;
      OPCODE_WIDTH'(OP_NOT): cls_o.lnot = 1'b1;
      OPCODE_WIDTH'(OP_JMP): cls_o.jmp  = 1'b1;
      OPCODE_WIDTH'(OP_JN):  cls_o.jn   = 1'b1;
      OPCODE_WIDTH'(OP_JZ):  cls_o.jz   = 1'b1;
      OPCODE_WIDTH'(OP_HLT): cls_o.hlt  = 1'b1;
      default:               cls_o.nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/neander_control_unit.sv
// Neander instruction-sequencing FSM: fetch (T0..T2), execute (T3..T7), HALT.
//   state | meaning
//   T0    | REM <- PC
//   T1    | RDM <- mem, PC++
//   T2    | RI <- RDM
//   T3    | decode: NOT/NOP/skip finish, HLT stops, others fetch operand address
//   T4    | RDM <- mem (operand address / jump target)
//   T5    | jump: PC <- RDM; mem-ref: REM <- RDM
//   T6    | RDM <- mem (load class) or AC (STA)
//   T7    | AC/NZ update, or memory write for STA
//   HALT  | idle until reset
module neander_control_unit
  import neander_pkg::*;
#(
  parameter int OPCODE_WIDTH  = 4,
  parameter int ALU_SEL_WIDTH = 3
) (
  input logic                   clk,
  input logic                   reset,
  neander_control_unit_if.master ctrl
);

  logic [3:0]   state_q, state_d;
  instr_class_t cls;
  logic         mem_ref, jump_taken, jump_skip;

  logic ld_rem, ld_rdm, ld_ri, ld_ac, ld_nz, ld_pc;
  logic pc_inc, addr_sel, rdm_sel, wr;
  logic [2:0] alu_code;

  neander_decoder #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_decoder (
    .opcode_i (ctrl.opcode),
    .cls_o    (cls)
  );

  assign mem_ref    = is_mem_ref(cls);
  assign jump_taken = cls.jmp | (cls.jn & ctrl.flag_n) | (cls.jz & ctrl.flag_z);
  assign jump_skip  = (cls.jn & ~ctrl.flag_n) | (cls.jz & ~ctrl.flag_z);

  always_comb begin
    state_d = S_T0;
    case (state_q)
      S_T0: state_d = S_T1;
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        if (cls.nop || cls.lnot)         state_d = S_T0;
        else if (cls.hlt)                state_d = S_HALT;
        else if (mem_ref || jump_taken)  state_d = S_T4;
        else                             state_d = S_T0;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = mem_ref ? S_T6 : S_T0;
      S_T6:   state_d = S_T7;
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_T0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_T0;
    else       state_q <= state_d;
  end

  // Flags are only consulted in T3; later jump states rely on having got there.
  always_comb begin
    ld_rem   = 1'b0;
    ld_rdm   = 1'b0;
    ld_ri    = 1'b0;
    ld_ac    = 1'b0;
    ld_nz    = 1'b0;
    ld_pc    = 1'b0;
    pc_inc   = 1'b0;
    addr_sel = 1'b0;
    rdm_sel  = 1'b0;
    wr       = 1'b0;
    alu_code = ALU_ADD;
    case (state_q)
      S_T0: ld_rem = 1'b1;
      S_T1: begin
        ld_rdm = 1'b1;
        pc_inc = 1'b1;
      end
      S_T2: ld_ri = 1'b1;
      S_T3: begin
        if (cls.lnot) begin
          ld_ac    = 1'b1;
          ld_nz    = 1'b1;
          alu_code = ALU_NOT;
        end else if (mem_ref || jump_taken) begin
          ld_rem = 1'b1;
        end else if (jump_skip) begin
          pc_inc = 1'b1;
        end
      end
      S_T4: begin
        ld_rdm = 1'b1;
        pc_inc = mem_ref;
      end
      S_T5: begin
        if (mem_ref) begin
          ld_rem   = 1'b1;
          addr_sel = 1'b1;
        end else begin
          ld_pc = 1'b1;
        end
      end
      S_T6: begin
        ld_rdm  = 1'b1;
        rdm_sel = cls.sta;
      end
      S_T7: begin
        if (cls.sta) begin
          wr = 1'b1;
        end else begin
          ld_ac = 1'b1;
          ld_nz = 1'b1;
          if (cls.lda)      alu_code = ALU_PASS_Y;
          else if (cls.lor) alu_code = ALU_OR;
          else if (cls.land) alu_code = ALU_AND;
          else              alu_code = ALU_ADD;
        end
      end
      default: ;
    endcase
  end

  assign ctrl.load_rem  = ld_rem   & ~reset;
  assign ctrl.load_rdm  = ld_rdm   & ~reset;
  assign ctrl.load_ri   = ld_ri    & ~reset;
  assign ctrl.load_ac   = ld_ac    & ~reset;
  assign ctrl.load_nz   = ld_nz    & ~reset;
  assign ctrl.load_pc   = ld_pc    & ~reset;
  assign ctrl.inc_pc    = pc_inc   & ~reset;
  assign ctrl.sel_addr  = addr_sel & ~reset;
  assign ctrl.sel_rdm   = rdm_sel  & ~reset;
  assign ctrl.mem_write = wr       & ~reset;
  assign ctrl.alu_sel   = reset ? '0 : ALU_SEL_WIDTH'(alu_code);
  assign ctrl.halted    = (state_q == S_HALT) & ~reset;

endmodule

// File: tb/tb_neander_control_unit.sv
// Directed cycle-by-cycle strobe traces for the Neander control unit.
module tb_neander_control_unit;

  localparam logic [13:0] REM   = 14'h2000;
  localparam logic [13:0] RDM   = 14'h1000;
  localparam logic [13:0] RI    = 14'h0800;
  localparam logic [13:0] AC    = 14'h0400;
  localparam logic [13:0] NZ    = 14'h0200;
  localparam logic [13:0] PC    = 14'h0100;
  localparam logic [13:0] INC   = 14'h0080;
  localparam logic [13:0] SADDR = 14'h0040;
  localparam logic [13:0] SRDM  = 14'h0020;
  localparam logic [13:0] WR    = 14'h0010;
  localparam logic [13:0] HLTD  = 14'h0008;

  typedef logic [13:0] trace_t [8];

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  neander_control_unit_if #(.OPCODE_WIDTH(4), .ALU_SEL_WIDTH(3)) ctrl ();

  neander_control_unit #(.OPCODE_WIDTH(4), .ALU_SEL_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl)
  );

  trace_t t_lda  = '{REM, RDM|INC, RI, REM, RDM|INC, REM|SADDR, RDM, AC|NZ|14'd4};
  trace_t t_sta  = '{REM, RDM|INC, RI, REM, RDM|INC, REM|SADDR, RDM|SRDM, WR};
  trace_t t_add  = '{REM, RDM|INC, RI, REM, RDM|INC, REM|SADDR, RDM, AC|NZ|14'd0};
  trace_t t_or   = '{REM, RDM|INC, RI, REM, RDM|INC, REM|SADDR, RDM, AC|NZ|14'd2};
  trace_t t_and  = '{REM, RDM|INC, RI, REM, RDM|INC, REM|SADDR, RDM, AC|NZ|14'd1};
  trace_t t_jmp  = '{REM, RDM|INC, RI, REM, RDM, PC, 14'h0, 14'h0};
  trace_t t_nop  = '{REM, RDM|INC, RI, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0};
  trace_t t_skip = '{REM, RDM|INC, RI, INC, 14'h0, 14'h0, 14'h0, 14'h0};
  trace_t t_not  = '{REM, RDM|INC, RI, AC|NZ|14'd3, 14'h0, 14'h0, 14'h0, 14'h0};

  function automatic logic [13:0] obs();
    return {ctrl.load_rem, ctrl.load_rdm, ctrl.load_ri, ctrl.load_ac, ctrl.load_nz,
            ctrl.load_pc, ctrl.inc_pc, ctrl.sel_addr, ctrl.sel_rdm, ctrl.mem_write,
            ctrl.halted, ctrl.alu_sel};
  endfunction

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks n cycles starting at the current one; flag bit i is driven during cycle i+1.
  task automatic run_seq(input string tag, input trace_t e, input int n,
                         input logic [7:0] fn, input logic [7:0] fz);
    for (int i = 0; i < n; i++) begin
      ctrl.flag_n = fn[i];
      ctrl.flag_z = fz[i];
      #1;
      chk($sformatf("%s c%0d", tag, i + 1), obs(), e[i]);
      step();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rst_zero%0d", i), obs(), 14'h0);
      step();
    end
    reset = 1'b0;
    #1;
    chk("rst_exit_t0", obs(), REM);
  endtask

  initial begin
    reset       = 1'b1;
    ctrl.opcode = 4'h5;
    ctrl.flag_n = 1'b0;
    ctrl.flag_z = 1'b0;
    step();
    do_reset(2);

    ctrl.opcode = 4'h2; run_seq("lda",  t_lda, 8, 8'h00, 8'h00);
    ctrl.opcode = 4'h1; run_seq("sta",  t_sta, 8, 8'hFF, 8'hFF);
    ctrl.opcode = 4'h3; run_seq("add",  t_add, 8, 8'h00, 8'h00);
    ctrl.opcode = 4'h4; run_seq("or",   t_or,  8, 8'h00, 8'h00);
    ctrl.opcode = 4'h5; run_seq("and",  t_and, 8, 8'h00, 8'h00);
    ctrl.opcode = 4'h6; run_seq("not",  t_not, 4, 8'h00, 8'h00);
    ctrl.opcode = 4'h0; run_seq("nop",  t_nop, 4, 8'h00, 8'h00);
    ctrl.opcode = 4'h7; run_seq("op7",  t_nop, 4, 8'hFF, 8'hFF);

    ctrl.opcode = 4'h9; run_seq("jn_tk",  t_jmp,  6, 8'b0000_1000, 8'h00);
    ctrl.opcode = 4'h9; run_seq("jn_nt",  t_skip, 4, 8'b1111_0111, 8'hFF);
    ctrl.opcode = 4'hA; run_seq("jz_tk",  t_jmp,  6, 8'h00, 8'hFF);
    ctrl.opcode = 4'hA; run_seq("jz_nt",  t_skip, 4, 8'hFF, 8'b1111_0111);
    ctrl.opcode = 4'h8; run_seq("jmp",    t_jmp,  6, 8'h00, 8'h00);
    ctrl.opcode = 4'h2; run_seq("lda2",   t_lda,  8, 8'h00, 8'h00);

    ctrl.opcode = 4'hF; run_seq("hlt", t_nop, 4, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) begin
      ctrl.flag_n = i[0];
      ctrl.flag_z = i[1];
      #1;
      chk($sformatf("halt c%0d", i + 5), obs(), HLTD);
      step();
    end
    do_reset(1);
    ctrl.opcode = 4'h0; run_seq("post_hlt", t_nop, 4, 8'h00, 8'h00);

    ctrl.opcode = 4'h3; run_seq("add_rst", t_add, 5, 8'h00, 8'h00);
    do_reset(2);
    ctrl.opcode = 4'h7; run_seq("op7_rst", t_nop, 4, 8'h00, 8'h00);
    #1;
    chk("final_t0", obs(), REM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/neander_control_unit.md
NEANDER_CONTROL_UNIT -- requirements
Module: neander_control_unit

Interface
REQ-001 The block SHALL have parameter OPCODE_WIDTH, default 4, meaning the opcode field width taken from the RI upper nibble.
REQ-002 The block SHALL have parameter ALU_SEL_WIDTH, default 3, meaning the ALU operation select width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 opcode  input  OPCODE_WIDTH  instruction opcode from the RI register output.
REQ-007 flag_n, flag_z  input  1 each  stored NZ flags.
REQ-008 load_rem, load_rdm, load_ri, load_ac, load_nz, load_pc  output  1 each  register enable strobes.
REQ-009 inc_pc  output  1  PC increment strobe.
REQ-010 sel_addr  output  1  REM source: 0 = PC, 1 = RDM.
REQ-011 sel_rdm  output  1  RDM source: 0 = memory, 1 = AC.
REQ-012 mem_write  output  1  memory write strobe.
REQ-013 alu_sel  output  ALU_SEL_WIDTH  ALU operation: 0 ADD, 1 AND, 2 OR, 3 NOT, 4 PASS_Y.
REQ-014 halted  output  1  high while in HALT.

Function
REQ-015 The FSM SHALL have states T0..T7 and HALT; outputs SHALL be Moore-decoded from the current state and the opcode input, with every strobe 0 unless listed below.
REQ-016 T0: load_rem=1, sel_addr=0. T1: load_rdm=1, sel_rdm=0, inc_pc=1. T2: load_ri=1. T0->T1->T2->T3 unconditionally.
REQ-017 Opcodes SHALL be: NOP 0x0, STA 0x1, LDA 0x2, ADD 0x3, OR 0x4, AND 0x5, NOT 0x6, JMP 0x8, JN 0x9, JZ 0xA, HLT 0xF; any other value SHALL execute as NOP.
REQ-018 NOP in T3: no strobes; T3->T0 (4 cycles total).
REQ-019 NOT in T3: load_ac=1, load_nz=1, alu_sel=3; T3->T0.
REQ-020 HLT in T3: T3->HALT; HALT SHALL hold with every strobe 0 and halted=1 until reset.
REQ-021 JN with flag_n=0, or JZ with flag_z=0: T3 inc_pc=1; T3->T0 (4 cycles).
REQ-022 JMP, taken JN (flag_n=1), taken JZ (flag_z=1): T3 load_rem=1, sel_addr=0; T4 load_rdm=1; T5 load_pc=1; T5->T0 (6 cycles).
REQ-023 STA/LDA/ADD/OR/AND: T3 load_rem=1, sel_addr=0; T4 load_rdm=1, inc_pc=1; T5 load_rem=1, sel_addr=1.
REQ-024 STA: T6 load_rdm=1, sel_rdm=1; T7 mem_write=1; load_ac and load_nz SHALL never assert.
REQ-025 LDA/ADD/OR/AND: T6 load_rdm=1, sel_rdm=0; T7 load_ac=1, load_nz=1, alu_sel = 4/0/2/1 respectively.
REQ-026 Memory-reference instructions SHALL take 8 cycles (T0..T7), with T7->T0.
REQ-027 Flags SHALL be sampled only in T3; flag changes in other states SHALL have no effect.
REQ-028 Each strobe SHALL be high for exactly one cycle per listed state, with no back-to-back duplicates.

Reset
REQ-029 reset high at a rising edge SHALL set state to T0 and halted to 0, from any state including HALT and mid-instruction.
REQ-030 While reset is high, all outputs SHALL be forced to 0, alu_sel included.
REQ-031 The first cycle after reset deasserts SHALL be T0 (load_rem=1, sel_addr=0).

Structure
REQ-032 Package neander_pkg SHALL hold the opcode constants, the state encoding, and the alu_sel codes, shared with the datapath and ALU.
REQ-033 The block SHALL include one combinational sub-module, neander_decoder, mapping opcode to one-hot instruction class (nop, sta, lda, add, or, and, not, jmp, jn, jz, hlt); the FSM SHALL contain only state and output logic.

Verification
REQ-034 Reset held 2 cycles from an arbitrary state -> all outputs 0 during reset; next cycle load_rem=1, sel_addr=0, halted=0.
REQ-035 opcode=0x2 (LDA) -> strobe trace T0..T7 exact; load_ac=1, load_nz=1, alu_sel=4 only in cycle 8; load_rem=1 again in cycle 9.
REQ-036 opcode=0x1 (STA) -> mem_write high exactly once in cycle 8 with sel_rdm=1 in cycle 7; load_ac never high.
REQ-037 opcode=0x9 with flag_n=1 -> load_pc in cycle 6, next T0 in cycle 7; with flag_n=0 -> inc_pc in cycle 4, T0 in cycle 5.
REQ-038 opcode=0xF -> halted=1 from cycle 5 and all strobes 0 for 20 cycles; then reset -> T0 with halted=0.
REQ-039 opcode=0x3 (ADD) with reset asserted in T5 -> no load_ac or load_nz ever; T0 on the cycle after reset deasserts; opcode=0x7 -> NOP timing (4 cycles).
